// File: rtl/data_mem_responder_if.sv
// Request/response bundle between the memory stage and the data memory responder.
// The master drives requests and halt; the slave returns load data and handshake pulses.
interface data_mem_responder_if;
  logic [15:0] addr;
  logic [15:0] data_in;
  logic        rd;
  logic        wr;
  logic        halt;
  logic [15:0] data_out;
  logic        stall;
  logic        done;
  logic        err;

  modport master (
    output addr, data_in, rd, wr, halt,
    input  data_out, stall, done, err
  );

  modport slave (
    input  addr, data_in, rd, wr, halt,
    output data_out, stall, done, err
  );
endinterface

// File: rtl/data_mem_responder.sv
// Word-addressed 16-bit data memory with fixed multi-cycle access latency,
// illegal-request detection and a sticky halted state left only through reset.
module data_mem_responder #(
  parameter int ADDR_BITS = 8,
  parameter int LATENCY   = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  data_mem_responder_if.slave  bus
);

  localparam int DEPTH = 1 << ADDR_BITS;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY   = 2'd1,
    HALTED = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [3:0]           count_q;
  logic [ADDR_BITS-1:0] idx_q;
  logic [15:0]          wdata_q;
  logic                 is_wr_q;
  logic [15:0]          data_out_q;
  logic                 done_q;
  logic                 err_q;
  logic                 err_d;
  logic [15:0]          mem_q [DEPTH];

  logic req, conflict, misaligned, accept, finish;
  logic unused_addr;

  // Upper address bits deliberately wrap onto the array.
  assign unused_addr = ^bus.addr[15:ADDR_BITS+1];

  assign req        = bus.rd | bus.wr;
  assign conflict   = bus.rd & bus.wr;
  assign misaligned = req & bus.addr[0];
  assign accept     = (state_q == IDLE) && req && !conflict && !misaligned;
  assign finish     = (state_q == BUSY) && (count_q == 4'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = BUSY;
        end else if (!req && bus.halt) begin
          state_d = HALTED;
        end
      end
      BUSY: begin
        if (finish) begin
          state_d = IDLE;
        end
      end
      HALTED:  state_d = HALTED;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.stall = (state_q == BUSY);
    err_d     = 1'b0;
    if (state_q == IDLE) begin
      err_d = conflict | misaligned;
    end else if (state_q == HALTED) begin
      err_d = req;
    end
  end

  assign bus.data_out = data_out_q;
  assign bus.done     = done_q;
  assign bus.err      = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q    <= 4'd0;
      idx_q      <= '0;
      wdata_q    <= 16'h0000;
      is_wr_q    <= 1'b0;
      data_out_q <= 16'h0000;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      done_q <= finish;
      err_q  <= err_d;
      if (accept) begin
        count_q <= 4'(LATENCY - 1);
        idx_q   <= bus.addr[ADDR_BITS:1];
        wdata_q <= bus.data_in;
        is_wr_q <= bus.wr;
      end else if ((state_q == BUSY) && (count_q != 4'd0)) begin
        count_q <= count_q - 4'd1;
      end
      if (finish && !is_wr_q) begin
        data_out_q <= mem_q[idx_q];
      end
    end
  end

  // Reset must clear every word, so the array is held in fabric registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 16'h0000;
      end
    end else if (finish && is_wr_q) begin
      mem_q[idx_q] <= wdata_q;
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench: directed vector table, hand-written corner sequences and
// randomized transactions checked against a transaction-level memory model.
module tb_data_mem_responder;

  localparam int AB    = 8;
  localparam int LAT   = 2;
  localparam int DEPTH = 1 << AB;

  logic clk = 1'b0;
  logic rst = 1'b1;

  data_mem_responder_if bus ();

  data_mem_responder #(.ADDR_BITS(AB), .LATENCY(LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] model_mem [DEPTH];
  logic [15:0] last_m;
  bit          halted_m;

  typedef struct {
    string       nm;
    bit          r, w, h;
    logic [15:0] a, d;
    bit          e_err, e_done;
    logic [15:0] e_dout;
  } vec_t;

  vec_t tbl [10];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.rd      = 1'b0;
    bus.wr      = 1'b0;
    bus.halt    = 1'b0;
    bus.addr    = 16'h0000;
    bus.data_in = 16'h0000;
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 16'h0000;
    last_m   = 16'h0000;
    halted_m = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
    model_reset();
    chk("reset_dout",  bus.data_out, 16'h0000);
    chk("reset_done",  bus.done,  1'b0);
    chk("reset_err",   bus.err,   1'b0);
    chk("reset_stall", bus.stall, 1'b0);
  endtask

  task automatic idle_gap();
    step();
    chk("gap_done",  bus.done,  1'b0);
    chk("gap_err",   bus.err,   1'b0);
    chk("gap_stall", bus.stall, 1'b0);
  endtask

  // Drives one request in the current cycle and follows it to its response cycle.
  task automatic txn(input bit r, input bit w, input bit h, input logic [15:0] a,
                     input logic [15:0] d, output bit o_err, output bit o_done,
                     output logic [15:0] o_dout);
    int idx;
    bit req, legal;
    idx   = (int'(a) / 2) % DEPTH;
    req   = r || w;
    legal = !halted_m && req && !(r && w) && (a % 2 == 0);
    bus.rd = r; bus.wr = w; bus.halt = h; bus.addr = a; bus.data_in = d;
    step();
    clear_inputs();
    if (legal) begin
      for (int k = 1; k <= LAT; k++) begin
        chk("busy_stall", bus.stall, 1'b1);
        chk("busy_done",  bus.done,  1'b0);
        chk("busy_err",   bus.err,   1'b0);
        // Requests and halt presented while stalled must be ignored.
        bus.rd = 1'($urandom); bus.wr = 1'($urandom); bus.halt = 1'($urandom);
        bus.addr = 16'($urandom); bus.data_in = 16'($urandom);
        step();
        clear_inputs();
      end
      if (w) model_mem[idx] = d;
      else   last_m = model_mem[idx];
      chk("resp_done",  bus.done,  1'b1);
      chk("resp_stall", bus.stall, 1'b0);
      chk("resp_err",   bus.err,   1'b0);
      chk("resp_dout",  bus.data_out, last_m);
    end else begin
      if (!halted_m && !req && h) halted_m = 1'b1;
      chk("nacc_err",   bus.err,   16'(req));
      chk("nacc_done",  bus.done,  1'b0);
      chk("nacc_stall", bus.stall, 1'b0);
      chk("nacc_dout",  bus.data_out, last_m);
    end
    o_err  = bus.err;
    o_done = bus.done;
    o_dout = bus.data_out;
    $display("txn rd=%0b wr=%0b halt=%0b addr=%h data=%h -> err=%0b done=%0b dout=%h",
             r, w, h, a, d, o_err, o_done, o_dout);
  endtask

  initial begin
    bit          oe, od;
    logic [15:0] odo;

    tbl[0] = '{"wr_beef",    0, 1, 0, 16'h0010, 16'hBEEF, 0, 1, 16'h0000};
    tbl[1] = '{"rd_beef",    1, 0, 0, 16'h0010, 16'h0000, 0, 1, 16'hBEEF};
    tbl[2] = '{"wr_1234",    0, 1, 0, 16'h0020, 16'h1234, 0, 1, 16'hBEEF};
    tbl[3] = '{"rd_b2b",     1, 0, 0, 16'h0020, 16'h0000, 0, 1, 16'h1234};
    tbl[4] = '{"rd_and_wr",  1, 1, 0, 16'h0004, 16'h7777, 1, 0, 16'h1234};
    tbl[5] = '{"rd_misalign",1, 0, 0, 16'h0003, 16'h0000, 1, 0, 16'h1234};
    tbl[6] = '{"wr_wrap",    0, 1, 0, 16'h0202, 16'h5A5A, 0, 1, 16'h1234};
    tbl[7] = '{"rd_wrap",    1, 0, 0, 16'h0002, 16'h0000, 0, 1, 16'h5A5A};
    tbl[8] = '{"wr_misalign",0, 1, 0, 16'h0003, 16'h9999, 1, 0, 16'h5A5A};
    tbl[9] = '{"rd_hi_wrap", 1, 0, 1, 16'hFE02, 16'h0000, 0, 1, 16'h5A5A};

    clear_inputs();
    model_reset();
    step();
    do_reset();

    // Consecutive table rows are presented back-to-back in the response cycle.
    for (int i = 0; i < 10; i++) begin
      txn(tbl[i].r, tbl[i].w, tbl[i].h, tbl[i].a, tbl[i].d, oe, od, odo);
      chk({tbl[i].nm, "_err"},  oe,  tbl[i].e_err);
      chk({tbl[i].nm, "_done"}, od,  tbl[i].e_done);
      chk({tbl[i].nm, "_dout"}, odo, tbl[i].e_dout);
    end
    idle_gap();

    // Halt with no request, then a store is rejected and the state is sticky.
    txn(0, 0, 1, 16'h0000, 16'h0000, oe, od, odo);
    txn(0, 1, 0, 16'h0010, 16'h0000, oe, od, odo);
    chk("halt_wr_err",  oe, 1'b1);
    chk("halt_wr_done", od, 1'b0);
    idle_gap();
    txn(1, 0, 0, 16'h0020, 16'h0000, oe, od, odo);
    chk("halt_rd_err",  oe, 1'b1);
    chk("halt_rd_dout", odo, 16'h5A5A);
    idle_gap();
    do_reset();
    txn(1, 0, 0, 16'h0010, 16'h0000, oe, od, odo);
    chk("post_halt_rd", odo, 16'h0000);
    idle_gap();

    // Reset arriving mid-access aborts the store and clears the array.
    txn(0, 1, 0, 16'h0040, 16'h1111, oe, od, odo);
    txn(1, 0, 0, 16'h0040, 16'h0000, oe, od, odo);
    chk("pre_abort_rd", odo, 16'h1111);
    bus.wr = 1'b1; bus.addr = 16'h0040; bus.data_in = 16'hFFFF;
    step();
    clear_inputs();
    chk("abort_stall", bus.stall, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    model_reset();
    chk("abort_dout",  bus.data_out, 16'h0000);
    chk("abort_done",  bus.done,  1'b0);
    chk("abort_stall2", bus.stall, 1'b0);
    for (int k = 0; k < LAT + 1; k++) begin
      step();
      chk("abort_no_done", bus.done, 1'b0);
    end
    txn(1, 0, 0, 16'h0040, 16'h0000, oe, od, odo);
    chk("abort_rd", odo, 16'h0000);
    idle_gap();

    // Randomized traffic against the model.
    for (int i = 0; i < 300; i++) begin
      int          kind;
      logic [15:0] a;
      if (halted_m && ($urandom % 3 == 0)) do_reset();
      kind = int'($urandom % 20);
      a    = 16'($urandom_range(0, 31)) * 16'd2;
      if ($urandom % 4 == 0) a = a | (16'($urandom) & 16'hFE00);
      if (kind == 0) begin
        txn(0, 0, 1, a, 16'h0000, oe, od, odo);
      end else if (kind == 1) begin
        txn(1, 1, 1'($urandom), a, 16'($urandom), oe, od, odo);
      end else if (kind == 2) begin
        txn(1'($urandom), 1'b1, 1'b0, a | 16'h0001, 16'($urandom), oe, od, odo);
      end else begin
        bit is_w;
        is_w = 1'($urandom);
        txn(!is_w, is_w, ($urandom % 4 == 0), a, 16'($urandom), oe, od, odo);
      end
      if ($urandom % 2 == 0) idle_gap();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Word-addressed data memory that serves load and store requests from the processor's memory stage.
- Multi-cycle: each accepted request completes after a fixed, parameterised latency, and the block signals this with a stall/done handshake.
- Detects illegal requests and holds in a halted state once the processor halts.
- Sits behind the memory stage in place of a single-cycle memory. The top level ORs its err into the global err output.

Parameters:
- ADDR_BITS, 8, log2 of the number of 16-bit words stored (2^ADDR_BITS words).
- LATENCY, 2, number of BUSY cycles per access; legal range 1..15.

Ports:
- clk  input  1  system clock, all state updates on the rising edge
- rst  input  1  synchronous, active-high reset
- addr  input  16  byte address; bit 0 must be 0; word index is addr[ADDR_BITS:1]
- data_in  input  16  store data
- rd  input  1  load request
- wr  input  1  store request
- halt  input  1  processor halt indication
- data_out  output  16  load result, registered
- stall  output  1  block busy; requests are ignored while high
- done  output  1  one-cycle completion pulse, registered
- err  output  1  one-cycle illegal-request pulse, registered

Behaviour:
- Reset, synchronous and active-high:
  - state=IDLE, counter=0.
  - data_out=0, done=0, err=0; stall=0 follows from IDLE.
  - All array words cleared to 0.
  - rst overrides every other input.
- States: IDLE, BUSY, HALTED. stall = (state==BUSY), combinational.
- IDLE, evaluated with the following priority:
  - rd&wr both high: err<=1, nothing accepted, stay IDLE.
  - (rd|wr) with addr[0]=1: err<=1, nothing accepted, stay IDLE.
  - Legal rd or wr: latch word index, data_in and op; counter<=LATENCY-1; state<=BUSY.
  - No request and halt=1: state<=HALTED.
  - If a legal request and halt arrive in the same cycle, the request is accepted and halt is ignored that cycle.
- BUSY:
  - If counter!=0: counter decrements.
  - If counter==0:
    - read: data_out<=mem[idx].
    - write: mem[idx]<=latched data; data_out is unchanged.
    - done<=1, state<=IDLE.
  - rd, wr and halt are ignored in BUSY. A requester that sees stall=1 must hold its request until stall is low and must not treat it as accepted.
- Timing: if the request is in cycle 0, stall is high in cycles 1..LATENCY. done and data_out are valid in cycle LATENCY+1. The block is IDLE in that same cycle, so a back-to-back request can be presented there.
- done and err are high for exactly one cycle per event. data_out holds the last load value until the next load completes.
- Addresses above the array size wrap: only addr[ADDR_BITS:1] is used, and upper bits are ignored without error.
- HALTED:
  - No accesses are performed; stall=0 and done=0.
  - Any rd or wr produces err<=1.
  - The only exit is rst.
- Reset during BUSY aborts the access: no write occurs, no done is produced, and the array is cleared.

Test Plan (LATENCY=2, ADDR_BITS=8):
- Write then read: wr addr=0x0010 data_in=0xBEEF in cycle 0 -> stall=1 in cycles 1-2, done=1 in cycle 3. Then rd addr=0x0010 in cycle 3 -> done=1 and data_out=0xBEEF in cycle 6.
- Back-to-back: after a write of 0x1234 to 0x0020, present rd of 0x0020 in the done cycle -> accepted immediately, data_out=0x1234 three cycles later. A rd presented while stall=1 is not accepted.
- Illegal requests: rd=wr=1 at addr 0x0004 -> err=1 for one cycle, no stall, no done. rd at addr 0x0003 -> err=1, data_out unchanged.
- Wrap-around: write 0x5A5A to addr 0x0202 -> a read of 0x0002 returns 0x5A5A.
- Halt: halt=1 while IDLE with no request -> HALTED. A later wr to 0x0010 with data 0x0000 -> err=1, no done, and a read after reset returns 0x0000.
- Reset mid-access: wr 0x0040 data 0xFFFF, rst asserted in cycle 1 -> no done. Following read of 0x0040 returns 0x0000 and data_out=0 after reset.
